// File: rtl/clk_div_detect.sv
// Divided-clock detector: measures the period and high time of an asynchronous
// divided clock, classifies the divide ratio and locks once it has been stable.
module clk_div_detect #(
  parameter int LOCK_COUNT     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sig_in,
  input  logic       meas_en,
  output logic [7:0] period,
  output logic       period_valid,
  output logic [7:0] duty_high,
  output logic [2:0] ratio_code,
  output logic       locked,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, SYNC, MEASURE, LOCKED} state_t;

  localparam logic [3:0] LOCK_CNT    = 4'(LOCK_COUNT);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_CYCLES);

  state_t     r_state;
  logic       r_s1;
  logic       r_s2;
  logic       r_s3;
  logic [7:0] r_cnt;
  logic [7:0] r_hcnt;
  logic [3:0] r_matchCnt;
  logic [7:0] r_period;
  logic [7:0] r_dutyHigh;
  logic       r_periodValid;
  logic [2:0] r_ratioCode;
  logic       r_locked;
  logic       r_timeout;

  logic       w_rise;
  logic       w_samePeriod;
  logic [2:0] w_candRatio;
  logic [3:0] w_nextMatch;

  // r_cnt holds the length of the period that closes on the current rise.
  always_comb begin
    w_rise       = r_s2 & ~r_s3;
    w_samePeriod = (r_cnt == r_period);
    case (r_cnt)
      8'd2:    w_candRatio = 3'd1;
      8'd4:    w_candRatio = 3'd2;
      8'd8:    w_candRatio = 3'd3;
      8'd16:   w_candRatio = 3'd4;
      default: w_candRatio = 3'd0;
    endcase
    if (!w_samePeriod) begin
      w_nextMatch = 4'd1;
    end else if (r_matchCnt >= LOCK_CNT) begin
      w_nextMatch = LOCK_CNT;
    end else begin
      w_nextMatch = r_matchCnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_s1          <= 1'b0;
      r_s2          <= 1'b0;
      r_s3          <= 1'b0;
      r_cnt         <= 8'd0;
      r_hcnt        <= 8'd0;
      r_matchCnt    <= 4'd0;
      r_period      <= 8'd0;
      r_dutyHigh    <= 8'd0;
      r_periodValid <= 1'b0;
      r_ratioCode   <= 3'd0;
      r_locked      <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_s1          <= sig_in;
      r_s2          <= r_s1;
      r_s3          <= r_s2;
      r_periodValid <= 1'b0;
      // Disabling abandons the measurement but keeps the last period/duty visible.
      if (!meas_en) begin
        r_state     <= IDLE;
        r_cnt       <= 8'd0;
        r_hcnt      <= 8'd0;
        r_matchCnt  <= 4'd0;
        r_ratioCode <= 3'd0;
        r_locked    <= 1'b0;
        r_timeout   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: r_state <= SYNC;
          SYNC: begin
            if (w_rise) begin
              r_cnt     <= 8'd1;
              r_hcnt    <= 8'd1;
              r_timeout <= 1'b0;
              r_state   <= MEASURE;
            end
          end
          MEASURE, LOCKED: begin
            if (w_rise) begin
              r_period      <= r_cnt;
              r_dutyHigh    <= r_hcnt;
              r_periodValid <= 1'b1;
              r_cnt         <= 8'd1;
              r_hcnt        <= 8'd1;
              r_timeout     <= 1'b0;
              r_matchCnt    <= w_nextMatch;
              if (r_state == LOCKED) begin
                if (!w_samePeriod) begin
                  r_state     <= MEASURE;
                  r_locked    <= 1'b0;
                  r_ratioCode <= 3'd0;
                end
              end else if ((w_nextMatch == LOCK_CNT) && (w_candRatio != 3'd0)) begin
                r_state     <= LOCKED;
                r_locked    <= 1'b1;
                r_ratioCode <= w_candRatio;
              end
            end else if (r_cnt >= TIMEOUT_CNT) begin
              r_timeout   <= 1'b1;
              r_locked    <= 1'b0;
              r_ratioCode <= 3'd0;
              r_matchCnt  <= 4'd0;
              r_state     <= SYNC;
            end else begin
              if (r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
              end
              if (r_s2 && (r_hcnt != 8'hFF)) begin
                r_hcnt <= r_hcnt + 8'd1;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign period       = r_period;
  assign period_valid = r_periodValid;
  assign duty_high    = r_dutyHigh;
  assign ratio_code   = r_ratioCode;
  assign locked       = r_locked;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_clk_div_detect.sv
// Bench for clk_div_detect: a table of divided-clock patterns feeds a scoreboard of
// expected measurements; timeout, disable and reset are exercised as hand sequences.
`timescale 1ns/1ps
module tb_clk_div_detect;

  localparam int LOCK = 4;
  localparam int TMO  = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       sig_in;
  logic       meas_en;
  logic [7:0] period;
  logic       period_valid;
  logic [7:0] duty_high;
  logic [2:0] ratio_code;
  logic       locked;
  logic       timeout;

  clk_div_detect #(.LOCK_COUNT(LOCK), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .sig_in       (sig_in),
    .meas_en      (meas_en),
    .period       (period),
    .period_valid (period_valid),
    .duty_high    (duty_high),
    .ratio_code   (ratio_code),
    .locked       (locked),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         high;
    int         low;
    int         reps;
    logic [7:0] expPeriod;
    logic [7:0] expDuty;
    logic [2:0] expRatio;
  } row_t;

  typedef struct {
    logic [7:0] period;
    logic [7:0] duty;
    logic [2:0] ratio;
    logic       locked;
    logic       gapCheck;
  } exp_t;

  row_t rows[7];
  exp_t expQ[$];
  exp_t monE;

  int testsRun     = 0;
  int testsFailed  = 0;
  int cyc          = 0;
  int lastPulseCyc = -1;

  // Stimulus-side view of the measurement run in progress.
  logic       havePrev = 1'b0;
  logic [7:0] prevP;
  logic [7:0] prevD;
  logic [2:0] prevR;
  int         prevIdx  = 0;
  int         segIdx   = 0;
  int         runLen   = 0;
  logic [7:0] lastMeasP = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic restartRun();
    havePrev = 1'b0;
    segIdx   = 0;
    runLen   = 0;
  endtask

  // Lock is expected once the last LOCK measurements of this run agree on a power of two.
  task automatic pushPrev();
    exp_t e;
    if ((runLen > 0) && (prevP == lastMeasP)) runLen++;
    else runLen = 1;
    lastMeasP  = prevP;
    e.period   = prevP;
    e.duty     = prevD;
    e.locked   = (runLen >= LOCK) && (prevR != 3'd0);
    e.ratio    = e.locked ? prevR : 3'd0;
    e.gapCheck = (prevIdx >= 2);
    expQ.push_back(e);
  endtask

  // One sig_in period starting with a rising edge; its measurement appears on the next rise.
  task automatic applyStimulus(input int high, input int low, input logic [7:0] expP,
                               input logic [7:0] expD, input logic [2:0] expR);
    if (havePrev) pushPrev();
    sig_in = 1'b1;
    repeat (high) @(negedge clk);
    sig_in = 1'b0;
    repeat (low) @(negedge clk);
    segIdx++;
    prevP    = expP;
    prevD    = expD;
    prevR    = expR;
    prevIdx  = segIdx;
    havePrev = 1'b1;
  endtask

  always @(negedge clk) begin
    if (period_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected period_valid", period_valid, 0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("period", period, monE.period);
        checkOutput("duty_high", duty_high, monE.duty);
        checkOutput("locked", locked, monE.locked);
        checkOutput("ratio_code", ratio_code, monE.ratio);
        if (monE.gapCheck) checkOutput("pulse spacing", cyc - lastPulseCyc, monE.period);
      end
      lastPulseCyc = cyc;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish within 100000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    int guard;
    rows[0] = '{1, 1, 6, 8'd2,  8'd1, 3'd1};
    rows[1] = '{2, 2, 6, 8'd4,  8'd2, 3'd2};
    rows[2] = '{4, 4, 6, 8'd8,  8'd4, 3'd3};
    rows[3] = '{8, 8, 6, 8'd16, 8'd8, 3'd4};
    rows[4] = '{3, 3, 6, 8'd6,  8'd3, 3'd0};
    rows[5] = '{4, 4, 6, 8'd8,  8'd4, 3'd3};
    rows[6] = '{2, 2, 6, 8'd4,  8'd2, 3'd2};

    reset   = 1'b1;
    sig_in  = 1'b0;
    meas_en = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset period", period, 0);
    checkOutput("reset duty_high", duty_high, 0);
    checkOutput("reset ratio_code", ratio_code, 0);
    checkOutput("reset locked", locked, 0);
    checkOutput("reset timeout", timeout, 0);
    checkOutput("reset period_valid", period_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    meas_en = 1'b1;
    repeat (3) @(negedge clk);

    restartRun();
    for (int r = 0; r < 7; r++) begin
      for (int k = 0; k < rows[r].reps; k++) begin
        applyStimulus(rows[r].high, rows[r].low, rows[r].expPeriod, rows[r].expDuty, rows[r].expRatio);
      end
    end

    // sig_in now stays low: timeout must fire 64 cycles after the last rise.
    c0 = lastPulseCyc;
    restartRun();
    guard = 0;
    while ((cyc < c0 + TMO - 1) && (guard < 500)) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("timeout wait bound", int'(guard < 500), 1);
    checkOutput("timeout one cycle early", timeout, 0);
    checkOutput("locked one cycle before timeout", locked, 1);
    @(negedge clk);
    checkOutput("timeout asserted", timeout, 1);
    checkOutput("locked cleared by timeout", locked, 0);
    checkOutput("ratio_code cleared by timeout", ratio_code, 0);
    checkOutput("period held at timeout", period, 4);

    sig_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("timeout held before rise", timeout, 1);
    sig_in = 1'b0;
    @(negedge clk);
    checkOutput("timeout cleared by rise", timeout, 0);
    checkOutput("no period_valid on resync rise", period_valid, 0);
    @(negedge clk);
    segIdx   = 1;
    prevIdx  = 1;
    prevP    = 8'd4;
    prevD    = 8'd2;
    prevR    = 3'd2;
    havePrev = 1'b1;
    repeat (5) applyStimulus(2, 2, 8'd4, 8'd2, 3'd2);

    guard = 0;
    while ((expQ.size() != 0) && (guard < 50)) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("scoreboard drained before disable", expQ.size(), 0);
    checkOutput("locked before disable", locked, 1);
    meas_en = 1'b0;
    restartRun();
    @(negedge clk);
    checkOutput("disable locked", locked, 0);
    checkOutput("disable ratio_code", ratio_code, 0);
    checkOutput("disable timeout", timeout, 0);
    checkOutput("disable period held", period, 4);
    checkOutput("disable duty_high held", duty_high, 2);
    checkOutput("disable period_valid", period_valid, 0);

    meas_en = 1'b1;
    repeat (3) @(negedge clk);
    repeat (6) applyStimulus(1, 1, 8'd2, 8'd1, 3'd1);
    checkOutput("locked before reset", locked, 1);
    checkOutput("ratio_code before reset", ratio_code, 1);
    // The next rise lands on the reset edge, so its pulse must be suppressed.
    reset = 1'b1;
    expQ.delete();
    restartRun();
    repeat (2) @(negedge clk);
    checkOutput("mid-run reset period", period, 0);
    checkOutput("mid-run reset duty_high", duty_high, 0);
    checkOutput("mid-run reset ratio_code", ratio_code, 0);
    checkOutput("mid-run reset locked", locked, 0);
    checkOutput("mid-run reset timeout", timeout, 0);
    checkOutput("mid-run reset period_valid", period_valid, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/clk_div_detect.md
CLK_DIV_DETECT -- requirements
Module: clk_div_detect

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 4: number of consecutive equal periods required to lock (range 2..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: number of clk cycles without a rising edge before timeout (range 17..255).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port sig_in, input, 1: divided clock under test (for example clk_div2..clk_div16); treated as asynchronous.
REQ-006 SHALL have port meas_en, input, 1: measurement enable.
REQ-007 SHALL have port period, output, 8: clk cycles between the last two detected rising edges.
REQ-008 SHALL have port period_valid, output, 1: one-cycle pulse when period and duty_high update.
REQ-009 SHALL have port duty_high, output, 8: number of cycles the synchronized sig_in was high during the last complete period.
REQ-010 SHALL have port ratio_code, output, 3: divide ratio, encoded 0 = unknown, 1 = div2, 2 = div4, 3 = div8, 4 = div16; values 5..7 unused.
REQ-011 SHALL have port locked, output, 1: ratio stable for LOCK_COUNT consecutive periods.
REQ-012 SHALL have port timeout, output, 1: no rising edge seen within TIMEOUT_CYCLES.

Function
REQ-013 SHALL pass sig_in through a 2-flop synchronizer (s1, s2) plus a history flop s3, with rise = s2 & ~s3.
REQ-014 SHALL assert rise on the 3rd clk edge after sig_in is first sampled high.
REQ-015 SHALL implement the state machine IDLE, SYNC, MEASURE, LOCKED.
REQ-016 IDLE: SHALL go to SYNC when meas_en = 1.
REQ-017 SHALL return to IDLE from any state when meas_en = 0; on that transition it clears locked, ratio_code and the match count, and holds period and duty_high.
REQ-018 SYNC: SHALL, on the first rise, load cnt = 1 and hcnt = 1 and go to MEASURE; period_valid is not asserted on this edge.
REQ-019 SHALL, in MEASURE and LOCKED with no rise, increment cnt by 1 per cycle, saturating at 255.
REQ-020 SHALL, in MEASURE and LOCKED with no rise, increment hcnt by 1 when s2 = 1, saturating at 255.
REQ-021 SHALL, on a rise in MEASURE or LOCKED, load period <= cnt and duty_high <= hcnt, pulse period_valid for one cycle, and reload cnt = 1 and hcnt = 1.
REQ-022 SHALL measure period 2/4/8/16 for a sig_in that toggles every 1/2/4/8 clk cycles.
REQ-023 SHALL compute candidate ratio from the new period: 2->1, 4->2, 8->3, 16->4, any other value -> 0.
REQ-024 SHALL, when the new period equals the previous period, increment match_cnt (saturating at LOCK_COUNT); otherwise it sets match_cnt = 1.
REQ-025 MEASURE -> LOCKED SHALL occur when match_cnt reaches LOCK_COUNT and the candidate ratio is nonzero; locked = 1 and ratio_code = candidate are registered in the same cycle.
REQ-026 SHALL never lock on a non-power-of-two period; ratio_code stays 0.
REQ-027 LOCKED -> MEASURE SHALL occur on a rise whose period differs from the locked period; locked = 0, ratio_code = 0 and match_cnt = 1 on that same edge.
REQ-028 SHALL, when cnt reaches TIMEOUT_CYCLES in MEASURE or LOCKED, set timeout = 1, clear locked and ratio_code, and go to SYNC.
REQ-029 SHALL clear timeout on the next rise, or when meas_en = 0.
REQ-030 SHALL give a rise precedence over timeout evaluation when both occur in the same cycle.
REQ-031 SHALL hold period_valid at 0 in IDLE and SYNC.

Reset
REQ-032 SHALL, while reset = 1 at a clk edge, clear all state to 0 and force state IDLE: s1, s2, s3, cnt, hcnt, match_cnt, period, duty_high, period_valid, ratio_code, locked and timeout.
REQ-033 reset SHALL take priority over meas_en and rise.
REQ-034 On reset asserted mid-measurement, no period_valid pulse SHALL occur on that edge.

Verification
REQ-035 SHALL cover: meas_en = 1, sig_in = div2 of clk -> period_valid pulses every 2 cycles, period = 2, duty_high = 1, locked = 1 and ratio_code = 1 after 4 matching periods.
REQ-036 SHALL cover: sig_in = div16 -> period = 16, duty_high = 8, ratio_code = 4, locked = 1 after the 4th equal period.
REQ-037 SHALL cover: locked on div8, then switch sig_in to div4 -> first differing period = 4 or transitional, locked drops the same edge, relocks with ratio_code = 2.
REQ-038 SHALL cover: locked on div4, then hold sig_in low -> timeout = 1 and locked = 0 exactly 64 cycles after the last rise; next rise clears timeout, no period_valid on it.
REQ-039 SHALL cover: sig_in with period 6 (3 high / 3 low) -> period = 6, duty_high = 3, ratio_code = 0, locked never asserts.
REQ-040 SHALL cover: reset asserted while locked, and separately meas_en dropped while locked -> all outputs 0 for reset; for meas_en low, locked = 0 and ratio_code = 0 while period holds its last value.
